fetch_unit: RTL

- Instruction fetch stage of the posit out-of-order core; directly upstream of the decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers instruction words with their PCs in a small fetch queue.
- Presents the queue head to the decoder over valid/ready; supports a redirect (branch/exception) that flushes all fetch state.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// general_defines: shared types and defaults for the fetch stage.
//   INSTR_W          - instruction word width
//   RESET_PC_DEFAULT - default PC loaded on reset
//   fq_entry_t       - {instr, pc} record held in the fetch queue and
//                      presented to the decoder
package general_defines;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for both the instruction
// queue and the per-request PC shadow queue.
//   clk, rst_n  - clock, async active-low reset (storage cleared to 0)
//   flush_i     - empties the FIFO next cycle; wins over push/pop
//   push_i      - write wdata_i (ignored when full unless popping too)
//   pop_i       - advance head (ignored when empty)
//   rdata_o     - head entry, read straight from registered storage
//   count_o     - number of valid entries
// DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i && !empty;
  // Full queue may still accept a write when the head leaves this cycle;
  // the write lands in the slot being vacated.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC, issues word requests to instruction memory, buffers the
// in-order responses with their PCs, and flushes on redirect.
//   clk, rst_n                    - clock, async active-low reset
//   imem_req_valid/ready/addr     - request channel (addr = current PC)
//   imem_rsp_valid/data           - in-order responses, no backpressure
//   redirect_valid/pc             - flush and restart at redirect_pc & ~3
//   dec_valid/ready/instr/pc      - queue head to the decoder
//   perf_fetch_cnt/perf_stall_cnt - only with FETCH_PERF_CNT_EN defined:
//                                   saturating counts of decoder handshakes
//                                   and decoder stall cycles
// PC_W must not exceed 32 (width of the queued pc field).
module fetch_unit
  import general_defines::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter int              FQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic [PC_W-1:0]    dec_pc
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            run_q;

  logic [CW-1:0]   fq_count, shadow_count;
  logic [PC_W-1:0] shadow_pc;
  fq_entry_t       rsp_entry, head;
  logic [CW:0]     inflight;
  logic            req_hs, rsp_take, rsp_drop, dec_hs;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Queue slots are reserved at request time, so a response always fits.
  assign inflight = {1'b0, fq_count} + {1'b0, out_q};

  // run_q keeps the request channel quiet while reset is asserted.
  assign imem_req_valid = run_q && !redirect_valid && (drop_q == '0) &&
                          (inflight < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (drop_q == '0);
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign dec_hs   = dec_valid && dec_ready;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
      // Everything still in flight after this cycle belongs to the old path.
      drop_d = out_d;
    end else begin
      if (req_hs)   pc_d   = pc_q + PC_W'(4);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      run_q  <= 1'b1;
    end
  end

  fetch_fifo #(.W(PC_W), .DEPTH(FQ_DEPTH)) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (rsp_take),
    .rdata_o (shadow_pc),
    .count_o (shadow_count)
  );

  always_comb begin
    rsp_entry       = '0;
    rsp_entry.instr = imem_rsp_data;
    rsp_entry.pc    = 32'(shadow_pc);
  end

  fetch_fifo #(.W($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (rsp_take),
    .wdata_i (rsp_entry),
    .pop_i   (dec_hs),
    .rdata_o (head),
    .count_o (fq_count)
  );

  assign dec_valid = (fq_count != '0);
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc[PC_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (dec_hs && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (dec_valid && !dec_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding means the memory side is broken.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (out_q != '0));
  a_rsp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_take |-> (shadow_count != '0));

endmodule
